// File: rtl/spdif_tx_scheduler.sv
// spdif_tx_scheduler: NCO en_2x generator, sample-pair FIFO and frame sequencer for an S/PDIF transmitter.
// Latency: o_en_2x is a registered NCO carry; o_drdy and data register one cycle after the frame's last en_2x.
// Backpressure: o_ready (registered) drops when the FIFO is full; an empty FIFO at a frame boundary flags underrun.
// Optional feature macro: SPDIF_SCHED_MUTE_EN (mute underrun frames instead of repeating the last pair).
module spdif_tx_scheduler #(
  parameter int NCO_W   = 24,
  parameter int FIFO_AW = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [NCO_W-1:0]   i_nco_inc,
  input  logic [23:0]        i_ldata,
  input  logic [23:0]        i_rdata,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_en_2x,
  output logic [23:0]        o_ldata,
  output logic [23:0]        o_rdata,
  output logic               o_drdy,
  output logic               o_running,
  output logic               o_underrun,
  output logic [15:0]        o_underrun_cnt,
  output logic [FIFO_AW:0]   o_fifo_level
);

  localparam int                LW       = FIFO_AW + 1;
  localparam int                DEPTH    = 1 << FIFO_AW;
  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
  localparam logic [NCO_W-1:0]  INC_MASK = {1'b0, {(NCO_W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [47:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr;
  logic [FIFO_AW-1:0]   r_rptr;
  logic [LW-1:0]        r_level;
  logic [LW-1:0]        w_level_nxt;
  logic                 r_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_load;
  logic                 w_underrun;
  logic                 w_frame_end;

  logic [NCO_W-1:0]     r_acc;
  logic [NCO_W-1:0]     w_inc;
  logic [NCO_W:0]       w_sum;
  logic                 r_en_2x;
  logic [6:0]           r_pcnt;

  logic                 r_drdy;
  logic                 r_underrun;
  logic [15:0]          r_ucnt;
  logic [23:0]          r_ldata;
  logic [23:0]          r_rdata;

  assign w_push      = i_valid & r_ready;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  // Increment MSB is masked so the accumulator can never carry on two consecutive cycles.
  assign w_inc       = i_nco_inc & INC_MASK;
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_inc};
  // Last en_2x of the frame is on the wire now; the boundary cycle is the next one.
  assign w_frame_end = (r_state == S_RUN) & r_en_2x & (r_pcnt == 7'd127);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and the pop / load / underrun decisions taken at frame edges.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_level != '0) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_frame_end) begin
          if (!i_enable) begin
            w_state_nxt = S_IDLE;
          end else if (r_level != '0) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_underrun = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {i_ldata, i_rdata};
  end

  // FIFO pointers, occupancy and registered ready (not full in the coming cycle).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_FULL);
    end
  end

  // NCO and pulse counter run only in RUN; elsewhere they are held at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_en_2x <= 1'b0;
      r_pcnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_sum[NCO_W-1:0];
      r_en_2x <= w_sum[NCO_W];
      if (r_en_2x) r_pcnt <= r_pcnt + 7'd1;
    end else begin
      r_acc   <= '0;
      r_en_2x <= 1'b0;
      r_pcnt  <= '0;
    end
  end

  // Transmitter-facing data, frame strobe and underrun accounting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ldata    <= '0;
      r_rdata    <= '0;
      r_drdy     <= 1'b0;
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_drdy     <= w_load | w_underrun;
      r_underrun <= w_underrun;
      if (w_underrun && (r_ucnt != 16'hFFFF)) r_ucnt <= r_ucnt + 16'd1;
      if (w_load) begin
        r_ldata <= r_mem[r_rptr][47:24];
        r_rdata <= r_mem[r_rptr][23:0];
      end else if (w_underrun) begin
`ifdef SPDIF_SCHED_MUTE_EN
        r_ldata <= '0;
        r_rdata <= '0;
`else
        r_ldata <= r_ldata;
        r_rdata <= r_rdata;
`endif
      end
    end
  end

  assign o_ready        = r_ready;
  assign o_en_2x        = r_en_2x;
  assign o_ldata        = r_ldata;
  assign o_rdata        = r_rdata;
  assign o_drdy         = r_drdy;
  assign o_running      = (r_state == S_RUN);
  assign o_underrun     = r_underrun;
  assign o_underrun_cnt = r_ucnt;
  assign o_fifo_level   = r_level;

endmodule

// File: tb/tb_spdif_tx_scheduler.sv
// Testbench for spdif_tx_scheduler: random feed and NCO increments against a pulse-count reference model.
// Model: en_2x pulse n of a run is floor(n*inc/2^W) stepping up; frames end after every 128th pulse.
// Samples outputs 1 time unit after each rising edge and drives the next inputs immediately after.
module tb_spdif_tx_scheduler;

  localparam int NCO_W   = 24;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef SPDIF_SCHED_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic              clk;
  logic              tb_rst;
  logic              tb_en;
  logic [NCO_W-1:0]  tb_inc;
  logic [23:0]       tb_l;
  logic [23:0]       tb_r;
  logic              tb_valid;
  logic              o_ready;
  logic              o_en_2x;
  logic [23:0]       o_ldata;
  logic [23:0]       o_rdata;
  logic              o_drdy;
  logic              o_running;
  logic              o_underrun;
  logic [15:0]       o_underrun_cnt;
  logic [FIFO_AW:0]  o_fifo_level;

  spdif_tx_scheduler #(.NCO_W(NCO_W), .FIFO_AW(FIFO_AW)) dut (
    .i_clk          (clk),
    .i_rst          (tb_rst),
    .i_enable       (tb_en),
    .i_nco_inc      (tb_inc),
    .i_ldata        (tb_l),
    .i_rdata        (tb_r),
    .i_valid        (tb_valid),
    .o_ready        (o_ready),
    .o_en_2x        (o_en_2x),
    .o_ldata        (o_ldata),
    .o_rdata        (o_rdata),
    .o_drdy         (o_drdy),
    .o_running      (o_running),
    .o_underrun     (o_underrun),
    .o_underrun_cnt (o_underrun_cnt),
    .o_fifo_level   (o_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int           m_mode = 0;    // 0 idle, 1 waiting for first sample, 2 running
  longint       m_n    = 0;    // cycles since the first load of this run
  longint       m_inc  = 0;
  logic [47:0]  q[$];
  logic         e_ready = 1'b0;
  logic         e_en    = 1'b0;
  logic         e_drdy  = 1'b0;
  logic         e_under = 1'b0;
  logic [23:0]  e_l     = '0;
  logic [23:0]  e_r     = '0;
  int           e_ucnt  = 0;

  // Bench bookkeeping
  int  cyc = 0;
  int  feed = 0;               // 0 off, 1 every cycle, 2 random
  bit  rate_chk = 1'b0;
  int  last_en_cyc = -1;
  int  last_bnd_cyc = -1;
  int  n_bnd = 0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint pulses_at(longint n);
    if (n <= 0) return 0;
    return (n * m_inc) >> NCO_W;
  endfunction

  task automatic model_load();
    logic [47:0] h;
    h = q.pop_front();
    e_l = h[47:24];
    e_r = h[23:0];
    e_drdy = 1'b1;
  endtask

  // Advances the model across one rising edge using the inputs present before it.
  task automatic model_step();
    logic push;
    logic [47:0] pd;
    push    = tb_valid && e_ready;
    pd      = {tb_l, tb_r};
    e_drdy  = 1'b0;
    e_under = 1'b0;
    e_en    = 1'b0;
    if (tb_rst) begin
      m_mode = 0;
      q.delete();
      e_ready = 1'b0;
      e_l = '0;
      e_r = '0;
      e_ucnt = 0;
    end else begin
      case (m_mode)
        0: if (tb_en) m_mode = 1;
        1: begin
          if (!tb_en) m_mode = 0;
          else if (q.size() > 0) begin
            model_load();
            m_mode = 2;
            m_n = 0;
            m_inc = longint'(tb_inc & 24'h7FFFFF);
          end
        end
        default: begin
          m_n++;
          if (pulses_at(m_n - 1) > pulses_at(m_n - 2) && (pulses_at(m_n - 1) % 128) == 0) begin
            if (!tb_en) m_mode = 0;
            else if (q.size() > 0) model_load();
            else begin
              e_drdy = 1'b1;
              e_under = 1'b1;
              if (e_ucnt < 65535) e_ucnt++;
              if (MUTE) begin
                e_l = '0;
                e_r = '0;
              end
            end
          end
          if (m_mode == 2) e_en = (pulses_at(m_n) > pulses_at(m_n - 1));
        end
      endcase
      if (push) q.push_back(pd);
      e_ready = (q.size() < DEPTH);
    end
  endtask

  task automatic set_feed(input int m);
    feed = m;
    tb_valid = (feed == 1) || (feed == 2 && $urandom_range(0, 1) == 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    chk("en_2x",    64'(o_en_2x),        64'(e_en));
    chk("drdy",     64'(o_drdy),         64'(e_drdy));
    chk("underrun", 64'(o_underrun),     64'(e_under));
    chk("ucnt",     64'(o_underrun_cnt), 64'(e_ucnt));
    chk("running",  64'(o_running),      64'(m_mode == 2));
    chk("level",    64'(o_fifo_level),   64'(q.size()));
    chk("ready",    64'(o_ready),        64'(e_ready));
    chk("ldata",    64'(o_ldata),        64'(e_l));
    chk("rdata",    64'(o_rdata),        64'(e_r));
    chk("en_consec", 64'(o_en_2x & prev_en), 64'd0);
    if (rate_chk && o_en_2x && last_en_cyc >= 0) chk("en_gap", 64'(cyc - last_en_cyc), 64'd4);
    if (o_en_2x) last_en_cyc = cyc;
    if (o_drdy && prev_en) begin
      if (rate_chk && last_bnd_cyc >= 0) chk("drdy_gap", 64'(cyc - last_bnd_cyc), 64'd512);
      if (rate_chk) n_bnd++;
      last_bnd_cyc = cyc;
    end
    prev_en = o_en_2x;
    tb_l = 24'($urandom);
    tb_r = 24'($urandom);
    tb_valid = (feed == 1) || (feed == 2 && $urandom_range(0, 1) == 1);
  endtask

  task automatic wait_stop(input string tag);
    for (int i = 0; i < 1300 && o_running; i++) tick();
    chk(tag, 64'(o_running), 64'd0);
  endtask

  initial begin
    int lvl0;
    int cnt;
    logic [47:0] last_c;
    tb_rst = 1'b1; tb_en = 1'b0; tb_inc = 24'h400000;
    tb_l = '0; tb_r = '0; tb_valid = 1'b0;
    repeat (3) tick();
    tb_rst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(o_ready), 64'd1);

    // Prefill to full with valid held high
    set_feed(1);
    repeat (12) tick();
    chk("full_level", 64'(o_fifo_level), 64'd4);
    chk("full_ready", 64'(o_ready), 64'd0);

    // Nominal rate: en_2x every 4 clk, boundary drdy every 512 clk
    set_feed(2);
    tb_en = 1'b1;
    rate_chk = 1'b1; last_en_cyc = -1; last_bnd_cyc = -1; n_bnd = 0;
    repeat (1700) tick();
    rate_chk = 1'b0;
    chk("frames", 64'(n_bnd), 64'd3);

    // Stop request after the 10th pulse of a frame
    for (int i = 0; i < 700 && !(o_en_2x && m_mode == 2 && (pulses_at(m_n) % 128) == 10); i++) tick();
    chk("p10_seen", 64'(o_en_2x), 64'd1);
    tb_en = 1'b0;
    set_feed(0);
    lvl0 = q.size();
    cnt = 0;
    for (int i = 0; i < 700 && o_running; i++) begin
      tick();
      if (o_en_2x) cnt++;
    end
    chk("stop_idle", 64'(o_running), 64'd0);
    chk("stop_pulses", 64'(cnt), 64'd118);
    repeat (5) tick();
    chk("stop_level", 64'(o_fifo_level), 64'(lvl0));

    // Reset in the middle of a running frame
    tb_en = 1'b1;
    set_feed(2);
    repeat (300) tick();
    tb_rst = 1'b1;
    tick();
    chk("rst_running", 64'(o_running), 64'd0);
    chk("rst_level",   64'(o_fifo_level), 64'd0);
    chk("rst_ready",   64'(o_ready), 64'd0);
    chk("rst_ldata",   64'(o_ldata), 64'd0);
    chk("rst_en2x",    64'(o_en_2x), 64'd0);
    tb_rst = 1'b0;
    tb_en = 1'b0;
    set_feed(0);
    tick();

    // Three pairs then starve: fourth boundary underruns
    set_feed(1);
    for (int i = 0; i < 20 && q.size() < 3; i++) tick();
    set_feed(0);
    chk("three_pushed", 64'(o_fifo_level), 64'd3);
    last_c = q[2];
    tb_en = 1'b1;
    for (int i = 0; i < 2500 && !o_underrun; i++) tick();
    chk("under_seen", 64'(o_underrun), 64'd1);
    chk("under_cnt",  64'(o_underrun_cnt), 64'd1);
    chk("under_l",    64'(o_ldata), MUTE ? 64'd0 : 64'(last_c[47:24]));
    chk("under_r",    64'(o_rdata), MUTE ? 64'd0 : 64'(last_c[23:0]));
    tb_en = 1'b0;
    wait_stop("stop_after_under");

    // Increment MSB is ignored: C00000 runs like 400000
    tb_inc = 24'hC00000;
    set_feed(2);
    tb_en = 1'b1;
    rate_chk = 1'b1; last_en_cyc = -1; last_bnd_cyc = -1;
    repeat (1100) tick();
    rate_chk = 1'b0;
    tb_en = 1'b0;
    wait_stop("stop_msb");

    // Random increment
    tb_inc = {1'($urandom_range(0, 1)), 1'b1, 22'($urandom)};
    tb_en = 1'b1;
    repeat (2200) tick();
    tb_en = 1'b0;
    wait_stop("stop_rand");
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
